// File: rtl/pip_pkg.sv
// Shared definitions for the pipeline hazard controller: register-address
// width, hazard-cause encoding and the MUL/DIV occupancy FSM states.
package pip_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        HZ_NONE = 3'd0,
        HZ_LU   = 3'd1,
        HZ_BR   = 3'd2,
        HZ_MC   = 3'd3,
        HZ_MEM  = 3'd4
    } hz_cause_t;

    typedef enum logic [0:0] {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/pip_sat_cnt.sv
// Saturating up-counter for pipeline performance statistics; holds at
// all-ones instead of wrapping.
module pip_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: prioritises memory wait,
// MUL/DIV occupancy, taken branch and load-use, and drives register controls.
//
// state   | meaning
// MC_IDLE | no MUL/DIV in flight; a start in EX launches one
// MC_BUSY | MUL/DIV occupying EX; cnt counts remaining stall cycles
module pip_hazard_ctrl #(
    parameter int REG_AW = pip_pkg::REG_AW,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              br_taken_ex,
    input  logic              mc_start_ex,
    input  logic              mem_ready,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_srst_n,
    output logic              idex_we,
    output logic              idex_srst_n,
    output logic              exmem_we,
    output logic              exmem_srst_n,
    output logic              memwb_we,
    output logic              memwb_srst_n,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    import pip_pkg::*;

    localparam logic [3:0] MC_LAT_M1 = 4'(MC_LAT - 1);

    mc_state_t  state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       memw, mcst, brf, lu;
    hz_cause_t  cause;

    assign memw = !mem_ready;
    assign brf  = br_taken_ex;
    assign lu   = ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // The MUL/DIV unit keeps counting through memory waits; only the
    // release into EX/MEM has to wait for memory to be ready.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mcst      = 1'b0;
        case (state)
            MC_IDLE: begin
                if (mc_start_ex && !memw) begin
                    mcst      = 1'b1;
                    cnt_nxt   = MC_LAT_M1;
                    state_nxt = MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (cnt != 4'd0) begin
                    mcst    = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else if (!memw) begin
                    state_nxt = MC_IDLE;
                end
            end
            default: state_nxt = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= MC_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign mc_busy = (state == MC_BUSY);

    always_comb begin
        if (memw)       cause = HZ_MEM;
        else if (mcst)  cause = HZ_MC;
        else if (brf)   cause = HZ_BR;
        else if (lu)    cause = HZ_LU;
        else            cause = HZ_NONE;
    end

    // Frozen registers keep srst_n high so only the we pin matters.
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_srst_n  = 1'b1;
        idex_we      = 1'b1;
        idex_srst_n  = 1'b1;
        exmem_we     = 1'b1;
        exmem_srst_n = 1'b1;
        memwb_we     = 1'b1;
        memwb_srst_n = 1'b1;
        case (cause)
            HZ_MEM: begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_we     = 1'b0;
                memwb_srst_n = 1'b0;
            end
            HZ_MC: begin
                pc_we        = 1'b0;
                ifid_we      = 1'b0;
                idex_we      = 1'b0;
                exmem_srst_n = 1'b0;
            end
            HZ_BR: begin
                ifid_srst_n = 1'b0;
                idex_srst_n = 1'b0;
            end
            HZ_LU: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_srst_n = 1'b0;
            end
            default: ;
        endcase
    end

    pip_sat_cnt #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (!pc_we),
        .cnt    (stall_cnt)
    );

    pip_sat_cnt #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (cause == HZ_BR),
        .cnt    (flush_cnt)
    );

endmodule
